// File: rtl/div_ctrl_if.sv
// div_ctrl_if -- bundle of all signals between div_ctrl, the decode stage and
// the iterative divider.
//   Decode side : req_valid/req_ready/req_a/req_b (DIV issue), hilo_rd (MFHI/MFLO),
//                 flush, stall
//   Divider side: div_start/div_dividend/div_divisor out, div_busy/div_q/div_r in
//   HI/LO side  : hi_wdata/lo_wdata/hilo_we, sticky dz_flag/tmo_flag
// The environment (pipeline + divider) uses 'master'; div_ctrl uses 'slave'.
interface div_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        hilo_rd;
    logic        flush;
    logic        stall;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_busy;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        hilo_we;
    logic        dz_flag;
    logic        tmo_flag;

    modport master (
        output req_valid, req_a, req_b, hilo_rd, flush, div_busy, div_q, div_r,
        input  req_ready, stall, div_start, div_dividend, div_divisor,
               hi_wdata, lo_wdata, hilo_we, dz_flag, tmo_flag
    );

    modport slave (
        input  req_valid, req_a, req_b, hilo_rd, flush, div_busy, div_q, div_r,
        output req_ready, stall, div_start, div_dividend, div_divisor,
               hi_wdata, lo_wdata, hilo_we, dz_flag, tmo_flag
    );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl -- sequencer between the decode stage and a multi-cycle signed
// divider. Accepts one DIV at a time, launches the divider, waits for it,
// and writes remainder/quotient to HI/LO with a one-cycle strobe. A zero
// divisor bypasses the divider (HI=dividend, LO=all ones, dz_flag). A
// watchdog aborts any wait state that lasts WATCHDOG cycles (tmo_flag).
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : div_ctrl_if.slave (request, pipeline control, divider, HI/LO)
// Parameter:
//   WATCHDOG : maximum cycles in WAITB/RUN/DRAIN before a timeout abort
module div_ctrl #(
    parameter int unsigned WATCHDOG = 63
) (
    input  logic      clock,
    input  logic      reset,
    div_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (WATCHDOG < 32'd2) ? 32'd1 : $clog2(WATCHDOG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WATCHDOG - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAITB  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      opa_r;
    logic [31:0]      opb_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic             req_ready_r;
    logic             div_start_r;
    logic             hilo_we_r;
    logic             busy_stall_r;
    logic             dz_flag_r;
    logic             tmo_flag_r;
    logic             accept_s;
    logic             zero_div_s;
    logic             wd_hit_s;
    logic             tmo_s;
    logic             capture_s;

    assign accept_s   = bus.req_valid && req_ready_r;
    assign zero_div_s = (bus.req_b == 32'd0);
    // cnt_r holds the cycles already spent in the current state, so this
    // cycle is the WATCHDOG-th one when it equals WATCHDOG-1.
    assign wd_hit_s   = (cnt_r == CNT_LAST);

    // Next-state decision plus the timeout and result-capture events.
    always_comb begin
        state_nxt_s = state_r;
        tmo_s       = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (zero_div_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LAUNCH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (bus.flush) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAITB;
                end
            end
            ST_WAITB: begin
                if (bus.flush) begin
                    state_nxt_s = ST_DRAIN;
                end else if (bus.div_busy) begin
                    state_nxt_s = ST_RUN;
                end else if (wd_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_WAITB;
                end
            end
            ST_RUN: begin
                // Completion wins over a timeout landing in the same cycle.
                if (bus.flush) begin
                    state_nxt_s = ST_DRAIN;
                end else if (!bus.div_busy) begin
                    state_nxt_s = ST_DONE;
                    capture_s   = 1'b1;
                end else if (wd_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!bus.div_busy) begin
                    state_nxt_s = ST_IDLE;
                end else if (wd_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    tmo_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, watchdog counter, operand/HI/LO registers and the
    // registered outputs, all decoded from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            opa_r        <= 32'd0;
            opb_r        <= 32'd0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            req_ready_r  <= 1'b1;
            div_start_r  <= 1'b0;
            hilo_we_r    <= 1'b0;
            busy_stall_r <= 1'b0;
            dz_flag_r    <= 1'b0;
            tmo_flag_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            div_start_r  <= (state_nxt_s == ST_LAUNCH);
            hilo_we_r    <= (state_nxt_s == ST_DONE);
            busy_stall_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);

            if (state_nxt_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_WAITB) || (state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (accept_s) begin
                opa_r <= bus.req_a;
                opb_r <= bus.req_b;
            end else begin
                opa_r <= opa_r;
                opb_r <= opb_r;
            end

            if (accept_s && zero_div_s) begin
                hi_r      <= bus.req_a;
                lo_r      <= 32'hFFFF_FFFF;
                dz_flag_r <= 1'b1;
            end else if (capture_s) begin
                hi_r <= bus.div_r;
                lo_r <= bus.div_q;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end

            if (tmo_s) begin
                tmo_flag_r <= 1'b1;
            end else begin
                tmo_flag_r <= tmo_flag_r;
            end
        end
    end

    assign bus.req_ready    = req_ready_r;
    assign bus.div_start    = div_start_r;
    assign bus.div_dividend = opa_r;
    assign bus.div_divisor  = opb_r;
    assign bus.hi_wdata     = hi_r;
    assign bus.lo_wdata     = lo_r;
    assign bus.dz_flag      = dz_flag_r;
    assign bus.tmo_flag     = tmo_flag_r;
    // A flush arriving while the write is being presented must kill it in
    // the same cycle, so the registered strobe is gated by the live flush.
    assign bus.hilo_we      = hilo_we_r && !bus.flush;
    // Busy states stall unconditionally. An HI/LO read stalls in any
    // non-idle state, and also in the cycle a DIV is accepted, since that
    // read would otherwise race the result being produced.
    assign bus.stall        = busy_stall_r ||
                              (bus.hilo_rd && (!req_ready_r || bus.req_valid));
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl -- self-checking bench for div_ctrl. A behavioural reference
// model (phase + arithmetic quotient/remainder) predicts every output each
// cycle; a bench-side divider model answers div_start. Directed cases pin
// latency and literal results, then randomized traffic runs against the model.
module tb_div_ctrl;
    localparam int WD = 63;
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_RUN = 3, P_DONE = 4, P_DRAIN = 5;

    logic clock;
    logic reset;
    div_ctrl_if bus();

    div_ctrl #(.WATCHDOG(WD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model
    int          m_ph;
    int          m_wait;
    logic [31:0] m_a, m_b, m_hi, m_lo;
    bit          m_dz, m_tmo;

    // divider environment model
    int          div_mode;   // 0: 32-cycle, 1: stuck busy, 2: random latency
    int          d_left;
    logic [31:0] d_q, d_r;

    // observation counters for the directed literal checks
    int we_cnt, we_cyc, start_cnt, stall_cnt, tmo_cyc, rdy_cyc;
    logic [31:0] we_hi, we_lo;

    function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        else return $signed(a) / $signed(b);
    endfunction

    function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return $signed(a) % $signed(b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_obs();
        we_cnt = 0; we_cyc = -1; start_cnt = 0; stall_cnt = 0; tmo_cyc = -1; rdy_cyc = -1;
        we_hi = 32'd0; we_lo = 32'd0;
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_wait = 0;
        m_a = 32'd0; m_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        m_dz = 1'b0; m_tmo = 1'b0;
        d_left = 0; d_q = 32'd0; d_r = 32'd0;
    endtask

    // Compare every output against what the model says this cycle.
    task automatic check_outputs();
        logic e_stall;
        e_stall = (m_ph != P_IDLE && m_ph != P_DONE) ||
                  (bus.hilo_rd && (m_ph != P_IDLE || bus.req_valid));
        chk("req_ready",    bus.req_ready, m_ph == P_IDLE);
        chk("div_start",    bus.div_start, m_ph == P_LAUNCH);
        chk("hilo_we",      bus.hilo_we,   (m_ph == P_DONE) && !bus.flush);
        chk("stall",        bus.stall,     e_stall);
        chk("div_dividend", bus.div_dividend, m_a);
        chk("div_divisor",  bus.div_divisor,  m_b);
        chk("hi_wdata",     bus.hi_wdata,  m_hi);
        chk("lo_wdata",     bus.lo_wdata,  m_lo);
        chk("dz_flag",      bus.dz_flag,   m_dz);
        chk("tmo_flag",     bus.tmo_flag,  m_tmo);
        if (bus.hilo_we === 1'b1) begin
            we_cnt++; we_cyc = cyc; we_hi = bus.hi_wdata; we_lo = bus.lo_wdata;
        end
        if (bus.div_start === 1'b1) start_cnt++;
        if (bus.stall === 1'b1) stall_cnt++;
        if (bus.tmo_flag === 1'b1 && tmo_cyc < 0) tmo_cyc = cyc;
        if (bus.req_ready === 1'b1 && rdy_cyc < 0) rdy_cyc = cyc;
    endtask

    // Advance the model by one clock edge using this cycle's inputs.
    task automatic model_step();
        int nxt;
        nxt = m_ph;
        case (m_ph)
            P_IDLE: if (bus.req_valid) begin
                m_a = bus.req_a; m_b = bus.req_b;
                if (bus.req_b == 32'd0) begin
                    m_hi = bus.req_a; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1; nxt = P_DONE;
                end else nxt = P_LAUNCH;
            end
            P_LAUNCH: nxt = bus.flush ? P_DRAIN : P_WAIT;
            P_WAIT: begin
                if (bus.flush) nxt = P_DRAIN;
                else if (bus.div_busy) nxt = P_RUN;
                else if (m_wait + 1 >= WD) begin nxt = P_IDLE; m_tmo = 1'b1; end
            end
            P_RUN: begin
                if (bus.flush) nxt = P_DRAIN;
                else if (!bus.div_busy) begin
                    m_hi = srem(m_a, m_b); m_lo = sdiv(m_a, m_b); nxt = P_DONE;
                end else if (m_wait + 1 >= WD) begin nxt = P_IDLE; m_tmo = 1'b1; end
            end
            P_DONE: nxt = P_IDLE;
            P_DRAIN: begin
                if (!bus.div_busy) nxt = P_IDLE;
                else if (m_wait + 1 >= WD) begin nxt = P_IDLE; m_tmo = 1'b1; end
            end
            default: nxt = P_IDLE;
        endcase
        m_wait = (nxt == m_ph) ? m_wait + 1 : 0;
        m_ph = nxt;
    endtask

    function automatic int pick_lat();
        int r;
        if (div_mode == 0) return 32;
        else if (div_mode == 1) return 1000000;
        r = $urandom_range(0, 99);
        if (r < 3) return 0;
        else if (r < 6) return 70;
        else return $urandom_range(1, 40);
    endfunction

    task automatic div_step();
        if (bus.div_start === 1'b1) begin
            d_q = sdiv(bus.div_dividend, bus.div_divisor);
            d_r = srem(bus.div_dividend, bus.div_divisor);
            d_left = pick_lat();
        end else if (d_left > 0) d_left--;
    endtask

    task automatic drive_div();
        bus.div_busy = (d_left > 0);
        bus.div_q = (d_left > 0) ? 32'($urandom) : d_q;
        bus.div_r = (d_left > 0) ? 32'($urandom) : d_r;
    endtask

    task automatic cycle();
        @(negedge clock);
        check_outputs();
        model_step();
        div_step();
        cyc++;
        @(posedge clock);
        #1;
        drive_div();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int acc);
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
        acc = cyc;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 32'd1);
        chk({tag, "_stall"},     bus.stall, 32'd0);
        chk({tag, "_div_start"}, bus.div_start, 32'd0);
        chk({tag, "_hilo_we"},   bus.hilo_we, 32'd0);
        chk({tag, "_dz_flag"},   bus.dz_flag, 32'd0);
        chk({tag, "_tmo_flag"},  bus.tmo_flag, 32'd0);
        chk({tag, "_hi"},        bus.hi_wdata, 32'd0);
        chk({tag, "_lo"},        bus.lo_wdata, 32'd0);
        chk({tag, "_dividend"},  bus.div_dividend, 32'd0);
        chk({tag, "_divisor"},   bus.div_divisor, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int acc;
        logic [31:0] ra, rb;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_a = 32'd0; bus.req_b = 32'd0;
        bus.hilo_rd = 1'b0; bus.flush = 1'b0;
        div_mode = 0;
        model_reset();
        drive_div();
        clear_obs();
        @(posedge clock); #1;
        check_reset_literals("por");
        reset = 1'b0;

        // 100 / 7 through a 32-cycle divider
        issue(32'd100, 32'd7, acc);
        clear_obs();
        repeat (40) cycle();
        chk("lat_100_7", 32'(we_cyc - acc), 32'd35);
        chk("we_cnt_100_7", 32'(we_cnt), 32'd1);
        chk("hi_100_7", we_hi, 32'd2);
        chk("lo_100_7", we_lo, 32'd14);
        chk("stall_cnt_100_7", 32'(stall_cnt), 32'd34);
        chk("start_cnt_100_7", 32'(start_cnt), 32'd1);

        // -100 / 7 (truncating signed division)
        issue(32'hFFFF_FF9C, 32'd7, acc);
        clear_obs();
        repeat (40) cycle();
        chk("lat_m100_7", 32'(we_cyc - acc), 32'd35);
        chk("hi_m100_7", we_hi, 32'hFFFF_FFFE);
        chk("lo_m100_7", we_lo, 32'hFFFF_FFF2);

        // 5 / 0 bypasses the divider
        issue(32'd5, 32'd0, acc);
        clear_obs();
        repeat (5) cycle();
        chk("lat_5_0", 32'(we_cyc - acc), 32'd1);
        chk("start_cnt_5_0", 32'(start_cnt), 32'd0);
        chk("hi_5_0", we_hi, 32'd5);
        chk("lo_5_0", we_lo, 32'hFFFF_FFFF);
        chk("dz_5_0", bus.dz_flag, 32'd1);

        // flush during RUN: drain until the divider finishes, no write
        issue(32'd20, 32'd3, acc);
        clear_obs();
        repeat (10) cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        repeat (40) cycle();
        chk("we_cnt_flush", 32'(we_cnt), 32'd0);
        chk("ready_back_flush", 32'(rdy_cyc - acc), 32'd35);
        chk("ready_end_flush", bus.req_ready, 32'd1);

        // stuck divider: watchdog abort after 63 RUN cycles
        div_mode = 1;
        issue(32'd9, 32'd2, acc);
        clear_obs();
        repeat (75) cycle();
        chk("tmo_cyc_stuck", 32'(tmo_cyc - acc), 32'd66);
        chk("we_cnt_stuck", 32'(we_cnt), 32'd0);
        chk("ready_stuck", bus.req_ready, 32'd1);

        // asynchronous reset mid-RUN, then a fresh request
        div_mode = 0;
        issue(32'd1000, 32'd33, acc);
        repeat (15) cycle();
        bus.hilo_rd = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_literals("midrun");
        model_reset();
        drive_div();
        @(posedge clock); #1;
        reset = 1'b0;
        bus.hilo_rd = 1'b0;
        issue(32'd1000, 32'd33, acc);
        clear_obs();
        repeat (40) cycle();
        chk("lat_post_reset", 32'(we_cyc - acc), 32'd35);
        chk("hi_post_reset", we_hi, 32'd10);
        chk("lo_post_reset", we_lo, 32'd30);

        // randomized traffic against the model
        div_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'd0 - 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            bus.req_valid = ($urandom_range(0, 5) == 0);
            bus.req_a = ra;
            bus.req_b = rb;
            bus.hilo_rd = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
